axi_lite_rr_scheduler: RTL and testbench

//  Shares one AXI4-Lite master port between NUM_REQ local requesters using round-robin arbitration.

---
 rtl/axi_lite_rr_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_axi_lite_rr_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rr_scheduler.sv
// ---------------------------------------------------------------------------
// axi_lite_rr_scheduler
//   Shares one AXI4-Lite master port between NUM_REQ local requesters.
//   Arbitration is round-robin. Each transaction is a single beat, and only
//   one transaction is outstanding at a time.
//
// Ports
//   aclk, areset_n          clock (rising edge), asynchronous active-low reset
//   req / req_we            per-requester request and direction (1 = write)
//   req_addr / req_wdata    packed per-requester address / write data
//   gnt                     one-hot owner of the transaction in flight
//   done                    one-cycle completion pulse to the owner
//   rsp_data / rsp_resp     read data and BRESP/RRESP of the last completion
//   aw*/w*/b*/ar*/r*        AXI4-Lite master channels (wstrb tied to all ones)
// ---------------------------------------------------------------------------
module axi_lite_rr_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [1:0]                     rsp_resp,
  output logic [ADDR_WIDTH-1:0]          awaddr,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready,
  output logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           arvalid,
  input  logic                           arready,
  input  logic [DATA_WIDTH-1:0]          rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rvalid,
  output logic                           rready
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD,
    S_RDATA
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  logic [PW-1:0]           pick;
  logic [PW-1:0]           next_ptr;

  // First set request bit at or above ptr, wrapping from NUM_REQ-1 to 0.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [PW-1:0]      ptr);
    logic [PW-1:0] sel;
    logic          found;
    int            j;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && r[j]) begin
        sel   = PW'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick     = rr_pick(req, rr_ptr_q);
  assign next_ptr = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        // The done cycle is spent in IDLE without arbitrating: the owner
        // still holds req high here, and must not be re-served.
        if (|done_q) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
        end else if (|req) begin
          owner_d = pick;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
          if (req_we[pick]) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d   = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            state_d   = S_RD;
            arvalid_d = 1'b1;
            araddr_d  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
      end
      S_WR: begin
        // AW and W complete independently; a dropped valid marks completion.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (bvalid) begin
          rsp_resp_d = bresp;
          done_d     = gnt_q;
          state_d    = S_IDLE;
        end
      end
      S_RD: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rvalid) begin
          rsp_data_d = rdata;
          rsp_resp_d = rresp;
          done_d     = gnt_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; every output returns to zero on reset.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rsp_data = rsp_data_q;
  assign rsp_resp = rsp_resp_q;
  assign awaddr   = awaddr_q;
  assign awvalid  = awvalid_q;
  assign wdata    = wdata_q;
  assign wstrb    = '1;
  assign wvalid   = wvalid_q;
  assign bready   = (state_q == S_WRESP);
  assign araddr   = araddr_q;
  assign arvalid  = arvalid_q;
  assign rready   = (state_q == S_RDATA);

endmodule

// File: tb/tb_axi_lite_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_rr_scheduler
//   Bench for axi_lite_rr_scheduler with four requesters and a behavioural
//   AXI4-Lite slave whose ready/response delays are set per transaction.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_rr_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      gnt, done;
  logic [DW-1:0]     rsp_data;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, wvalid, arvalid, bready, rready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic              bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]        bresp = 2'd0, rresp = 2'd0;
  logic [DW-1:0]     rdata = '0;

  axi_lite_rr_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]    bresp_cfg = 2'd0, rresp_cfg = 2'd0;
  logic [DW-1:0] rdata_cfg = '0;

  int   aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int   b_count = 0;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, ar_got;
  logic aw_prev, w_prev, ar_prev;
  logic [AW-1:0] seen_awaddr = '0, seen_araddr = '0;
  logic [DW-1:0] seen_wdata = '0;

  // Handshake flags computed at a negedge describe the following posedge.
  always @(negedge aclk) begin
    if (!areset_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = '0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_prev = 0; w_prev = 0; ar_prev = 0;
    end else begin
      if (aw_prev && !awvalid) check("awvalid_held_until_ready", aw_hs, 1);
      if (w_prev && !wvalid)   check("wvalid_held_until_ready", w_hs, 1);
      if (ar_prev && !arvalid) check("arvalid_held_until_ready", ar_hs, 1);

      if (aw_hs) begin aw_got = 1; awready = 0; aw_wait = 0; end
      if (w_hs)  begin w_got = 1;  wready = 0;  w_wait = 0;  end
      if (ar_hs) begin ar_got = 1; arready = 0; ar_wait = 0; end
      if (b_hs)  begin bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; b_count++; end
      if (r_hs)  begin rvalid = 0; ar_got = 0; r_wait = 0; end

      if (awvalid && !awready) begin
        if (aw_wait >= aw_dly) awready = 1; else aw_wait++;
      end
      if (wvalid && !wready) begin
        if (w_wait >= w_dly) wready = 1; else w_wait++;
      end
      if (arvalid && !arready) begin
        if (ar_wait >= ar_dly) arready = 1; else ar_wait++;
      end
      if (aw_got && w_got && !bvalid) begin
        if (b_wait >= b_dly) begin bvalid = 1; bresp = bresp_cfg; end else b_wait++;
      end
      if (ar_got && !rvalid) begin
        if (r_wait >= r_dly) begin rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; end
        else r_wait++;
      end

      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      b_hs  = bvalid && bready;
      r_hs  = rvalid && rready;
      if (aw_hs) seen_awaddr = awaddr;
      if (w_hs)  seen_wdata  = wdata;
      if (ar_hs) seen_araddr = araddr;
      aw_prev = awvalid; w_prev = wvalid; ar_prev = arvalid;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            owner;
    logic          rd;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  always @(negedge aclk) begin
    if (areset_n) begin
      if (gnt != '0) check("gnt_onehot", $onehot(gnt), 1);
      if (done != '0) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          sb_e = sb_q.pop_front();
          check("done_owner", done, 64'(1) << sb_e.owner);
          check("rsp_resp", rsp_resp, sb_e.resp);
          if (sb_e.rd) check("rsp_data", rsp_data, sb_e.data);
        end
      end
    end
  end

  // ---------------- requester ----------------
  task automatic do_txn(input int idx, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int lat);
    int n;
    bit seen;
    @(negedge aclk);
    req_we[idx] = we;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wd;
    req[idx] = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge aclk);
      n++;
      // Once granted, scramble the request fields; the DUT must ignore this.
      if (n == 1 && gnt[idx]) begin
        req_we[idx] = ~we;
        req_addr[idx*AW +: AW]  = ~addr;
        req_wdata[idx*DW +: DW] = ~wd;
      end
      if (done[idx]) seen = 1;
    end
    check("done_seen", seen, 1);
    req[idx] = 1'b0;
    lat = n;
  endtask

  function automatic exp_t mk(input int owner, input logic rd, input logic [DW-1:0] d,
                              input logic [1:0] r);
    exp_t e;
    e.owner = owner; e.rd = rd; e.data = d; e.resp = r;
    return e;
  endfunction

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    int            lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_a, lat_b, b0;

    vecs[0] = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'd0, 32'h0,       3};
    vecs[1] = '{1, 1'b0, 32'h20, 32'h0,        0, 0, 0, 0, 5, 2'd2, 32'h12345678, 8};
    vecs[2] = '{2, 1'b1, 32'h30, 32'hCAFEF00D, 2, 0, 1, 0, 0, 2'd2, 32'h0,       6};
    vecs[3] = '{3, 1'b0, 32'h40, 32'h0,        0, 0, 0, 2, 0, 2'd3, 32'hA5A55A5A, 5};
    vecs[4] = '{0, 1'b1, 32'h50, 32'h01020304, 0, 3, 0, 0, 0, 2'd0, 32'h0,       6};
    vecs[5] = '{1, 1'b1, 32'h60, 32'h55AA55AA, 0, 0, 0, 0, 0, 2'd1, 32'h0,       3};

    // ---------------- reset state ----------------
    repeat (3) @(negedge aclk);
    check("reset_ctrl", {gnt, done, awvalid, wvalid, arvalid, bready, rready}, 0);
    check("reset_rsp", {rsp_data, rsp_resp}, 0);
    check("reset_addr", {awaddr, araddr}, 0);
    check("reset_wdata", wdata, 0);
    areset_n = 1'b1;

    // ---------------- two requesters from reset: 0,1,0,1 ----------------
    sb_q.push_back(mk(0, 0, '0, 2'd0));
    sb_q.push_back(mk(1, 0, '0, 2'd0));
    sb_q.push_back(mk(0, 0, '0, 2'd0));
    sb_q.push_back(mk(1, 0, '0, 2'd0));
    fork
      begin
        do_txn(0, 1'b1, 32'h100, 32'h1000, lat_a);
        do_txn(0, 1'b1, 32'h104, 32'h1004, lat_a);
      end
      begin
        do_txn(1, 1'b1, 32'h200, 32'h2000, lat_b);
        do_txn(1, 1'b1, 32'h204, 32'h2004, lat_b);
      end
    join
    repeat (2) @(negedge aclk);
    check("rr_queue_drained", sb_q.size(), 0);

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 6; i++) begin
      aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; b_dly = vecs[i].b_d;
      ar_dly = vecs[i].ar_d; r_dly = vecs[i].r_d;
      bresp_cfg = vecs[i].resp; rresp_cfg = vecs[i].resp; rdata_cfg = vecs[i].rdata;
      sb_q.push_back(mk(vecs[i].idx, !vecs[i].we, vecs[i].rdata, vecs[i].resp));
      b0 = b_count;
      do_txn(vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      repeat (2) @(negedge aclk);
      check($sformatf("latency_v%0d", i), lat, vecs[i].lat);
      if (vecs[i].we) begin
        check($sformatf("awaddr_v%0d", i), seen_awaddr, vecs[i].addr);
        check($sformatf("wdata_v%0d", i), seen_wdata, vecs[i].wdata);
        check($sformatf("b_handshakes_v%0d", i), b_count - b0, 1);
      end else begin
        check($sformatf("araddr_v%0d", i), seen_araddr, vecs[i].addr);
        check($sformatf("rsp_data_hold_v%0d", i), rsp_data, vecs[i].rdata);
      end
      check($sformatf("queue_v%0d", i), sb_q.size(), 0);
    end
    check("wstrb_all_ones", wstrb, 4'hF);
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    bresp_cfg = 0; rresp_cfg = 0;

    // ---------------- round-robin with rr_ptr = 2: req 1010 -> 3 then 1 ----------------
    // The last table transaction was owned by requester 1, so rr_ptr is 2.
    sb_q.push_back(mk(3, 0, '0, 2'd0));
    sb_q.push_back(mk(1, 0, '0, 2'd0));
    fork
      do_txn(3, 1'b1, 32'h300, 32'h3000, lat_a);
      do_txn(1, 1'b1, 32'h310, 32'h3100, lat_b);
    join
    repeat (2) @(negedge aclk);
    check("ptr2_order_latency_3", lat_a, 3);
    check("ptr2_order_latency_1", lat_b, 7);
    check("ptr2_queue", sb_q.size(), 0);

    // ---------------- asynchronous reset during WRESP ----------------
    b_dly = 20;
    @(negedge aclk);
    req_we[0] = 1'b1; req_addr[0 +: AW] = 32'h400; req_wdata[0 +: DW] = 32'h4000;
    req[0] = 1'b1;
    lat = 0;
    while (!bready && lat < 50) begin @(negedge aclk); lat++; end
    check("wresp_reached", bready, 1);
    #2 areset_n = 1'b0;
    #1;
    check("async_reset_ctrl", {gnt, done, awvalid, wvalid, arvalid, bready, rready}, 0);
    check("async_reset_rsp", {rsp_data, rsp_resp}, 0);
    req[0] = 1'b0;
    b_dly = 0;
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    repeat (2) @(negedge aclk);
    check("lost_txn_no_done", done, 0);

    // req0 idle: req1 is served.
    sb_q.push_back(mk(1, 0, '0, 2'd0));
    do_txn(1, 1'b1, 32'h500, 32'h5000, lat);
    check("post_reset_req1_latency", lat, 3);
    // Both pending with rr_ptr = 2: req0 wins first.
    sb_q.push_back(mk(0, 0, '0, 2'd0));
    sb_q.push_back(mk(1, 0, '0, 2'd0));
    fork
      do_txn(0, 1'b1, 32'h600, 32'h6000, lat_a);
      do_txn(1, 1'b0, 32'h610, 32'h0,    lat_b);
    join
    repeat (3) @(negedge aclk);
    check("post_reset_req0_first", lat_a, 3);
    check("post_reset_queue", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
